uart_tx_periph: RTL and testbench
=================================

# uart_tx_periph

Memory-mapped UART transmitter that sits directly downstream of the peripheral bus and is selected by its `cs_uart` strobe. Store data, the word address and the byte mask from the bus drive a small register file. Loads return status through a combinational read mux. A bit-timing state machine serialises bytes as 8N1 frames on `tx_o`.

## Interface
Parameters:
- `DW`, 32: data bus width.
- `DIV_W`, 16: baud divisor width.
- `DEFAULT_DIV`, 868: divisor at reset (100 MHz / 115200).
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two; used only when `UART_TX_FIFO_EN` is defined.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cs_i` in 1: chip select from the bus (`cs_uart`).
- `we_i` in 1: 1 = store, 0 = load.
- `addr_i` in 2: word index. 0 = TXDATA, 1 = STATUS, 2 = BAUDDIV, 3 = reserved.
- `data_store_i` in DW: store data.
- `mask_i` in 4: byte-lane enables.
- `data_load_o` out DW: read data, combinational.
- `tx_o` out 1: serial line, idle high.

## Operation
- **Write to TXDATA** (`cs_i & we_i & addr_i==0 & mask_i[0]`): byte `data_store_i[7:0]` is accepted when a slot exists.
  - A slot exists when the FSM is IDLE and no byte is pending, or when the FIFO is not full.
  - If no slot exists, the byte is dropped and STATUS.OVF is set.
- **Write to STATUS**: writing 1 to bit 1 clears OVF. All other bits are read-only.
- **Write to BAUDDIV**: updates `div_q[DIV_W-1:0]` from lanes 0–1, honouring each lane's mask bit.
  - The new value applies at the next bit boundary. The bit in progress is never shortened.
  - A stored value of 0 is treated as 1.
- **Reads**, zero-extended to DW:
  - TXDATA reads 0.
  - STATUS reads `{…0, full, ovf, busy}`.
  - BAUDDIV reads `div_q`.
  - Reserved reads 0.
  - When `cs_i` = 0, `data_load_o` = 0.
- **FSM states**: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if a byte is available, load the shift register and go to START.
  - START: `tx_o` = 0 for one bit time, then go to DATA.
  - DATA: 8 bits, LSB first; the shift register shifts right at each bit boundary. The bit counter goes 0..7; after bit 7, go to STOP.
  - STOP: `tx_o` = 1 for one bit time. Then go to START if another byte is available, else IDLE. Back-to-back frames have no idle gap.
- **Baud counter**:
  - Loaded with `div_q-1` on entry to each bit and decremented each cycle.
  - A bit boundary occurs when the counter reaches 0.
- **Status flags**:
  - `busy` = (state != IDLE) | byte pending.
  - `full` = no slot available.

## Timing
- **Reset values**:
  - `tx_o` = 1, state IDLE, `div_q` = DEFAULT_DIV.
  - OVF = 0, busy = 0, FIFO empty.
  - `data_load_o` follows the read mux and reads 0 while `cs_i` = 0.
- **Latency**: a TXDATA write accepted at edge N (IDLE, empty) gives `tx_o` = 0 from edge N+1.
- **Frame length**: 10·div cycles. `busy` falls at edge N+1+10·div for a single byte.
- **Status visibility**: STATUS read in the same cycle as a write returns pre-write state. The update is visible the following cycle.
- **Simultaneous events**:
  - If a write arrives in the same cycle as a STOP→IDLE transition, the write is accepted, and the next frame starts one cycle later.
  - If a TXDATA write and a FIFO pop occur on the same edge with the FIFO full, the write is accepted.
- **Reset mid-frame**: `tx_o` returns to 1 immediately (asynchronous). The frame and any pending bytes are discarded.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - Pending storage is a FIFO_DEPTH-entry FIFO.
  - `full` = FIFO count == FIFO_DEPTH.
- `UART_TX_FIFO_EN` undefined:
  - A single holding register with valid bit; the FSM consumes it at entry to START.
  - Effectively one byte in flight plus one pending.
  - `full` = holding valid & state != IDLE.
  - FIFO_DEPTH is ignored.

## Structure
- **Shared package `uart_pkg`**:
  - `uart_state_e` enum (IDLE, START, DATA, STOP).
  - Register index constants (`UART_TXDATA`=0, `UART_STATUS`=1, `UART_BAUDDIV`=2).
  - STATUS bit positions (`ST_BUSY`=0, `ST_OVF`=1, `ST_FULL`=2).
- **Sub-module `uart_tx_fifo`**: synchronous FIFO with push/pop/full/empty/count, instantiated only under `UART_TX_FIFO_EN`.

## Test plan
- **Single frame**: reset; write BAUDDIV=4; write TXDATA=0x55 → `tx_o` sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles each (start, LSB-first data, stop), starting the cycle after the write. `busy` is 1 for 40 cycles, then 0.
- **Overflow**: FIFO disabled, div=4; write 0xA0, 0xA1, 0xA2 on consecutive cycles → 0xA0 and 0xA1 are sent back-to-back with no gap, 0xA2 is dropped, STATUS reads 0x3. Write STATUS=0x2 → OVF clears.
- **FIFO fill**: FIFO enabled, depth 4, div=2; write 6 bytes back-to-back → 5 are sent, `full` is asserted after the 5th write, OVF is set by the 6th.
- **Divisor edges**: write BAUDDIV=0 → each bit lasts 1 cycle. Write BAUDDIV=8 mid-bit of a div=4 frame → the current bit stays 4 cycles, the next bit lasts 8.
- **Reset mid-frame**: deassert `rst_n` during a data bit → `tx_o`=1 asynchronously; after release, `busy`=0 and BAUDDIV reads DEFAULT_DIV.
- **Chip select gating**: stores with `cs_i`=0 or `mask_i[0]`=0 to TXDATA → no frame starts. Loads with `cs_i`=0 → `data_load_o`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

    localparam int ST_BUSY = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_FULL = 2;
endpackage

// File: rtl/uart_tx_periph_if.sv
// Peripheral bus slice seen by the UART: chip select, store/load, word address, byte mask.
interface uart_tx_periph_if #(parameter int DW = 32);
    logic          cs_i;
    logic          we_i;
    logic [1:0]    addr_i;
    logic [DW-1:0] data_store_i;
    logic [3:0]    mask_i;
    logic [DW-1:0] data_load_o;

    modport master (output cs_i, we_i, addr_i, data_store_i, mask_i, input data_load_o);
    modport slave  (input cs_i, we_i, addr_i, data_store_i, mask_i, output data_load_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO for pending TX bytes; DEPTH must be a power of two >= 2.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    // Push into a full FIFO is legal when a pop happens on the same edge.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) begin
            mem_d[wptr_q] = din_i;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop_i) rptr_d = rptr_q + 1'b1;
        cnt_d = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, read mux and bit-timing FSM.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int DW          = 32,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_periph_if.slave   bus,
    output logic              tx_o
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, div_eff;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             ovf_q, ovf_d;
    logic             wr_tx, wr_st, wr_div, accept, pend, pop, full, busy, bit_end;
    logic [7:0]       pend_byte;
    logic [DW-1:0]    rdata;
    logic             unused_bits;

    assign wr_tx  = bus.cs_i & bus.we_i & (bus.addr_i == UART_TXDATA) & bus.mask_i[0];
    assign wr_st  = bus.cs_i & bus.we_i & (bus.addr_i == UART_STATUS) & bus.mask_i[0]
                  & bus.data_store_i[ST_OVF];
    assign wr_div = bus.cs_i & bus.we_i & (bus.addr_i == UART_BAUDDIV);

    assign div_eff = (div_q == '0) ? ONE : div_q;
    assign bit_end = (cnt_q == '0);
    assign busy    = (state_q != IDLE) | pend;
    assign unused_bits = ^{bus.data_store_i[DW-1:DIV_W], bus.mask_i[3:2]};

`ifdef UART_TX_FIFO_EN
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   unused_fifo_cnt;

    assign accept = wr_tx & (~full | pop);
    assign pend   = ~fifo_empty;

    uart_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .din_i   (bus.data_store_i[7:0]),
        .pop_i   (pop),
        .dout_o  (pend_byte),
        .full_o  (full),
        .empty_o (fifo_empty),
        .count_o (unused_fifo_cnt)
    );
`else
    localparam int unused_depth = FIFO_DEPTH;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    // In IDLE the pending byte is consumed this edge, so the slot is free again.
    assign full      = hold_vld_q & (state_q != IDLE);
    assign accept    = wr_tx & ~full;
    assign pend      = hold_vld_q;
    assign pend_byte = hold_q;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (pop) hold_vld_d = 1'b0;
        if (accept) begin
            hold_d     = bus.data_store_i[7:0];
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    // Divisor is sampled only when reloading the baud counter, so a rewrite never cuts a bit short.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
        if (state_q != IDLE) cnt_d = bit_end ? div_eff - ONE : cnt_q - ONE;
        case (state_q)
            IDLE: if (pend) begin
                state_d = START;
                sh_d    = pend_byte;
                pop     = 1'b1;
                cnt_d   = div_eff - ONE;
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (bit_end) begin
                sh_d = {1'b0, sh_q[7:1]};
                if (bit_q == 3'd7) state_d = STOP;
                else               bit_d   = bit_q + 3'd1;
            end
            STOP: if (bit_end) begin
                if (pend) begin
                    state_d = START;
                    sh_d    = pend_byte;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_st) ovf_d = 1'b0;
        if (wr_tx && !accept) ovf_d = 1'b1;
        div_d = div_q;
        if (wr_div && bus.mask_i[0]) div_d[7:0]       = bus.data_store_i[7:0];
        if (wr_div && bus.mask_i[1]) div_d[DIV_W-1:8] = bus.data_store_i[DIV_W-1:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DIV_W'(DEFAULT_DIV);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = sh_q[0];
            default: tx_o = 1'b1;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (bus.cs_i) begin
            case (bus.addr_i)
                UART_STATUS: begin
                    rdata[ST_BUSY] = busy;
                    rdata[ST_OVF]  = ovf_q;
                    rdata[ST_FULL] = full;
                end
                UART_BAUDDIV: rdata[DIV_W-1:0] = div_q;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.data_load_o = rdata;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: directed bus writes feed expected frames to a scoreboard
// queue; a line monitor decodes tx_o cycle by cycle and compares against it.
module tb_uart_tx_periph;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] first;
        logic [15:0] rest;
        logic        b2b;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_o;
    int   n_chk = 0;
    int   n_fail = 0;
    frame_t exp_q[$];

    uart_tx_periph_if #(.DW(32)) bus();

    uart_tx_periph #(.DW(32), .DIV_W(16), .DEFAULT_DIV(868), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .tx_o  (tx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic frame_t mkf(input logic [7:0] b, input int first, input int rest, input logic b2b);
        frame_t f;
        f.b = b; f.first = 16'(first); f.rest = 16'(rest); f.b2b = b2b;
        return f;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_store_i = d; bus.mask_i = m;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.cs_i = 1'b0; bus.we_i = 1'b0; bus.mask_i = 4'h0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
        #1 check(name, bus.data_load_o, exp);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        logic [31:0] st;
        do begin
            @(negedge clk);
            bus.cs_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = UART_STATUS;
            #1 st = bus.data_load_o;
            n++;
        end while (st[ST_BUSY] && n < 400);
        check(name, {31'd0, st[ST_BUSY]}, 32'd0);
    endtask

    // Line monitor: a falling edge outside a frame starts the next expected frame.
    initial begin : monitor
        frame_t cur;
        bit   in_f = 0;
        int   bitn = 0, pos = 0, errs = 0, gap = 0, blen;
        logic prev = 1'b1;
        logic lvl;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_f = 0; prev = 1'b1; gap = 0;
            end else begin
                if (!in_f && prev === 1'b1 && tx_o === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_frame: start bit seen, no frame expected");
                    end else begin
                        cur = exp_q.pop_front();
                        if (cur.b2b) check("frame_gap", 32'(gap), 32'd0);
                        in_f = 1; bitn = 0; pos = 0; errs = 0;
                    end
                end
                if (in_f) begin
                    lvl  = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : cur.b[bitn-1];
                    if (tx_o !== lvl) errs++;
                    pos++;
                    blen = (bitn == 0) ? int'(cur.first) : int'(cur.rest);
                    if (pos == blen) begin
                        pos = 0; bitn++;
                        if (bitn == 10) begin
                            check($sformatf("frame_%02h_bits", cur.b), 32'(errs), 32'd0);
                            in_f = 0; gap = 0;
                        end
                    end
                end else if (tx_o === 1'b1) begin
                    gap++;
                end
                prev = tx_o;
            end
        end
    end

    initial begin : watchdog
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.cs_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 2'd0; bus.data_store_i = '0; bus.mask_i = 4'h0;
        repeat (3) @(negedge clk);
        #1 check("reset_tx_o", {31'd0, tx_o}, 32'd1);
        rst_n = 1'b1;
        rd_chk(UART_STATUS, 32'd0, "reset_status");
        rd_chk(UART_BAUDDIV, 32'd868, "reset_bauddiv");
        rd_chk(UART_TXDATA, 32'd0, "txdata_reads_0");
        rd_chk(2'd3, 32'd0, "reserved_reads_0");

        // single frame, div 4
        wr(UART_BAUDDIV, 32'd4, 4'hF); idle();
        rd_chk(UART_BAUDDIV, 32'd4, "bauddiv_4");
        exp_q.push_back(mkf(8'h55, 4, 4, 1'b0));
        wr(UART_TXDATA, 32'h55, 4'h1);
        idle();
        check("latency_idle_cycle", {31'd0, tx_o}, 32'd1);
        @(negedge clk);
        check("latency_start_bit", {31'd0, tx_o}, 32'd0);
        repeat (38) @(negedge clk);
        rd_chk(UART_STATUS, 32'd1, "busy_last_cycle");
        rd_chk(UART_STATUS, 32'd0, "busy_cleared");

`ifndef UART_TX_FIFO_EN
        // overflow with single holding register
        exp_q.push_back(mkf(8'hA0, 4, 4, 1'b0));
        exp_q.push_back(mkf(8'hA1, 4, 4, 1'b1));
        wr(UART_TXDATA, 32'hA0, 4'h1);
        wr(UART_TXDATA, 32'hA1, 4'h1);
        wr(UART_TXDATA, 32'hA2, 4'h1);
        idle();
        rd_chk(UART_STATUS, 32'h7, "ovf_full_pending");
        repeat (46) @(negedge clk);
        rd_chk(UART_STATUS, 32'h3, "ovf_status");
        wr(UART_STATUS, 32'h2, 4'h1); idle();
        rd_chk(UART_STATUS, 32'h1, "ovf_cleared");
        wait_idle("ovf_drain");
`else
        // FIFO fill, div 2
        wr(UART_BAUDDIV, 32'd2, 4'hF);
        for (int i = 0; i < 5; i++) exp_q.push_back(mkf(8'h10 + 8'(i), 2, 2, i != 0));
        for (int i = 0; i < 6; i++) wr(UART_TXDATA, 32'h10 + 32'(i), 4'h1);
        rd_chk(UART_STATUS, 32'h7, "fifo_full_ovf");
        wr(UART_STATUS, 32'h2, 4'h1); idle();
        rd_chk(UART_STATUS, 32'h5, "fifo_ovf_cleared");
        wait_idle("fifo_drain");
`endif

        // divisor 0 acts as 1
        wr(UART_BAUDDIV, 32'd0, 4'hF); idle();
        rd_chk(UART_BAUDDIV, 32'd0, "bauddiv_0");
        exp_q.push_back(mkf(8'h3C, 1, 1, 1'b0));
        wr(UART_TXDATA, 32'h3C, 4'h1); idle();
        wait_idle("div0_done");

        // lane masking on BAUDDIV
        wr(UART_BAUDDIV, 32'h0000_0008, 4'hF);
        wr(UART_BAUDDIV, 32'hABCD_1234, 4'h2); idle();
        rd_chk(UART_BAUDDIV, 32'h1208, "bauddiv_lane1_only");

        // divisor change mid start bit: start keeps 4, rest use 8
        wr(UART_BAUDDIV, 32'd4, 4'hF); idle();
        exp_q.push_back(mkf(8'hC3, 4, 8, 1'b0));
        wr(UART_TXDATA, 32'hC3, 4'h1);
        idle(); idle();
        wr(UART_BAUDDIV, 32'd8, 4'h3); idle();
        wait_idle("divchg_done");

        // chip select and mask gating
        wr(UART_BAUDDIV, 32'd4, 4'hF);
        @(negedge clk);
        bus.cs_i = 1'b0; bus.we_i = 1'b1; bus.addr_i = UART_TXDATA; bus.data_store_i = 32'h77; bus.mask_i = 4'hF;
        @(negedge clk);
        bus.cs_i = 1'b1; bus.mask_i = 4'hE;
        idle();
        bus.addr_i = UART_BAUDDIV;
        #1 check("cs0_load_zero", bus.data_load_o, 32'd0);
        repeat (20) @(negedge clk);
        rd_chk(UART_STATUS, 32'd0, "gated_no_frame");

        // reset during a data bit
        exp_q.push_back(mkf(8'hF0, 4, 4, 1'b0));
        wr(UART_TXDATA, 32'hF0, 4'h1); idle();
        repeat (7) @(negedge clk);
        check("pre_reset_tx_low", {31'd0, tx_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("async_reset_tx", {31'd0, tx_o}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk(UART_STATUS, 32'd0, "post_reset_status");
        rd_chk(UART_BAUDDIV, 32'd868, "post_reset_bauddiv");

        idle();
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
